// File: rtl/flash_read_responder.sv
// flash_read_responder
//   Flash-side responder for the controller's weight/bias fetch protocol.
//   A one-cycle request (i_flash_ready-style strobe + word address) triggers
//   an access on an asynchronous parallel flash with WAIT_STATES fixed wait
//   cycles. A one-word prefetch buffer holds address+1 so that the
//   controller's sequential walk is served in one cycle.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flash_ready       request strobe, one cycle
//   flash_address     word address, sampled with flash_ready
//   flashData_out     returned word, held until the next delivery
//   data_valid        one-cycle pulse with each flashData_out update
//   busy              a demand fetch is outstanding
//   overrun           sticky: a request arrived while busy and was dropped
//   mem_addr          flash address bus (registered)
//   mem_ce_n/mem_oe_n flash chip/output enable, active low (registered)
//   mem_data          flash data bus
module flash_read_responder #(
  parameter int WAIT_STATES = 4,
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flash_ready,
  input  logic [15:0] flash_address,
  output logic [15:0] flashData_out,
  output logic        data_valid,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] mem_addr,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  input  logic [15:0] mem_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CAP   = 2'd3;

  localparam logic K_DEMAND   = 1'b0;
  localparam logic K_PREFETCH = 1'b1;

  localparam logic [2:0] CNT_LAST = 3'(WAIT_STATES - 1);

  logic [1:0]  r_state;
  logic        r_kind;
  logic [2:0]  r_cnt;
  logic [15:0] r_target;
  logic        r_pf_valid;
  logic [15:0] r_pf_addr;
  logic [15:0] r_pf_data;
  logic [15:0] r_data;
  logic        r_dv;
  logic        r_overrun;
  logic [15:0] r_mem_addr;
  logic        r_ce_n;
  logic        r_oe_n;

  logic        w_active, w_busy, w_in_pf;
  logic        w_hit, w_miss, w_promote, w_abort;
  logic        w_cap_dem, w_cap_pf;
  logic        w_start;
  logic [15:0] w_start_addr;
  logic        w_start_kind;

  assign w_active = (r_state != S_IDLE);
  assign w_busy   = w_active && (r_kind == K_DEMAND);
  assign w_in_pf  = w_active && (r_kind == K_PREFETCH);

  assign w_hit  = flash_ready && !w_active && PREFETCH_EN && r_pf_valid &&
                  (r_pf_addr == flash_address);
  assign w_miss = flash_ready && !w_active && !w_hit;

  // A request that matches the in-flight prefetch target simply re-labels
  // the access; any other address throws the prefetch away.
  assign w_promote = flash_ready && w_in_pf && (flash_address == r_target);
  assign w_abort   = flash_ready && w_in_pf && (flash_address != r_target);

  // Promotion in the capture cycle itself still delivers this cycle's sample.
  assign w_cap_dem = (r_state == S_CAP) && ((r_kind == K_DEMAND) || w_promote);
  assign w_cap_pf  = (r_state == S_CAP) && (r_kind == K_PREFETCH) && !flash_ready;

  always_comb begin
    w_start      = 1'b0;
    w_start_addr = r_target;
    w_start_kind = K_DEMAND;
    if (w_hit) begin
      w_start      = 1'b1;
      w_start_addr = flash_address + 16'd1;
      w_start_kind = K_PREFETCH;
    end else if (w_miss || w_abort) begin
      w_start      = 1'b1;
      w_start_addr = flash_address;
      w_start_kind = K_DEMAND;
    end else if (w_cap_dem && PREFETCH_EN) begin
      w_start      = 1'b1;
      w_start_addr = r_target + 16'd1;
      w_start_kind = K_PREFETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_kind     <= K_DEMAND;
      r_cnt      <= 3'd0;
      r_target   <= 16'd0;
      r_pf_valid <= 1'b0;
      r_pf_addr  <= 16'd0;
      r_pf_data  <= 16'd0;
      r_data     <= 16'd0;
      r_dv       <= 1'b0;
      r_overrun  <= 1'b0;
      r_mem_addr <= 16'd0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
    end else begin
      r_dv <= w_hit || w_cap_dem;
      if (w_hit)
        r_data <= r_pf_data;
      else if (w_cap_dem)
        r_data <= mem_data;

      if (w_busy && flash_ready)
        r_overrun <= 1'b1;

      if (w_hit || w_miss) begin
        r_pf_valid <= 1'b0;
      end else if (w_cap_pf) begin
        r_pf_valid <= 1'b1;
        r_pf_addr  <= r_target;
        r_pf_data  <= mem_data;
      end

      if (w_promote)
        r_kind <= K_DEMAND;

      // Back-to-back accesses keep the strobes low; only mem_addr moves.
      if (w_start) begin
        r_state    <= S_SETUP;
        r_target   <= w_start_addr;
        r_kind     <= w_start_kind;
        r_mem_addr <= w_start_addr;
        r_ce_n     <= 1'b0;
        r_oe_n     <= 1'b0;
      end else begin
        case (r_state)
          S_SETUP: begin
            r_state <= S_WAIT;
            r_cnt   <= 3'd0;
          end
          S_WAIT: begin
            if (r_cnt == CNT_LAST)
              r_state <= S_CAP;
            else
              r_cnt <= r_cnt + 3'd1;
          end
          S_CAP: begin
            r_state <= S_IDLE;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign flashData_out = r_data;
  assign data_valid    = r_dv;
  assign busy          = w_busy;
  assign overrun       = r_overrun;
  assign mem_addr      = r_mem_addr;
  assign mem_ce_n      = r_ce_n;
  assign mem_oe_n      = r_oe_n;

endmodule

// File: tb/tb_flash_read_responder.sv
// Testbench for flash_read_responder: directed scenarios followed by a
// randomized phase, all checked every cycle against a transaction-level
// model (access start time + fixed duration, one-word prefetch buffer).
module tb_flash_read_responder;

  localparam int WS = 4;
  localparam bit PE = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flash_ready;
  logic [15:0] flash_address;
  logic [15:0] flashData_out;
  logic        data_valid;
  logic        busy;
  logic        overrun;
  logic [15:0] mem_addr;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic [15:0] mem_data;

  logic [15:0] fmem [0:65535];

  always #5 clk = ~clk;

  // Flash model: data only while both enables are low.
  assign mem_data = (!mem_ce_n && !mem_oe_n) ? fmem[mem_addr] : 16'hxxxx;

  flash_read_responder #(.WAIT_STATES(WS), .PREFETCH_EN(PE)) dut (
    .clk(clk), .rst(rst), .flash_ready(flash_ready), .flash_address(flash_address),
    .flashData_out(flashData_out), .data_valid(data_valid), .busy(busy),
    .overrun(overrun), .mem_addr(mem_addr), .mem_ce_n(mem_ce_n),
    .mem_oe_n(mem_oe_n), .mem_data(mem_data)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;

  // reference model state
  bit          m_act, m_dem, m_pfv, m_dv, m_ovr;
  logic [15:0] m_tgt, m_pfa, m_pfd, m_out;
  int          m_cap;

  // last observed outputs
  bit          last_dv, last_busy, last_oe, last_ce, last_ovr;
  logic [15:0] last_out, last_maddr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic m_reset();
    m_act = 0; m_dem = 0; m_pfv = 0; m_dv = 0; m_ovr = 0;
    m_tgt = 0; m_pfa = 0; m_pfd = 0; m_out = 0; m_cap = 0;
  endtask

  // access started by an event in cycle cyc_n: SETUP next cycle, WS wait
  // cycles, then CAPTURE
  task automatic start_acc(input logic [15:0] a, input bit dem);
    m_act = 1; m_tgt = a; m_dem = dem; m_cap = cyc_n + 2 + WS;
  endtask

  task automatic cyc(input bit r, input bit req, input logic [15:0] a);
    @(posedge clk);
    #1;
    rst = r; flash_ready = req; flash_address = a;
    @(negedge clk);
    if (chk_en) begin
      chk("data_valid", 16'(data_valid), 16'(m_dv));
      chk("flashData_out", flashData_out, m_out);
      chk("busy", 16'(busy), 16'(m_act && m_dem));
      chk("overrun", 16'(overrun), 16'(m_ovr));
      chk("mem_ce_n", 16'(mem_ce_n), 16'(!m_act));
      chk("mem_oe_n", 16'(mem_oe_n), 16'(!m_act));
      if (m_act) chk("mem_addr", mem_addr, m_tgt);
    end
    last_dv = data_valid; last_busy = busy; last_oe = mem_oe_n; last_ce = mem_ce_n;
    last_ovr = overrun; last_out = flashData_out; last_maddr = mem_addr;
    m_dv = 0;
    if (r) begin
      m_reset();
    end else begin
      if (req) begin
        if (m_act && m_dem) m_ovr = 1;
        else if (m_act) begin
          if (a == m_tgt) m_dem = 1;
          else start_acc(a, 1);
        end else if (PE && m_pfv && m_pfa == a) begin
          m_out = m_pfd; m_dv = 1; m_pfv = 0;
          start_acc(a + 16'd1, 0);
        end else begin
          m_pfv = 0;
          start_acc(a, 1);
        end
      end
      if (m_act && m_cap == cyc_n) begin
        if (m_dem) begin
          m_out = fmem[m_tgt]; m_dv = 1;
          if (PE) start_acc(m_tgt + 16'd1, 0);
          else m_act = 0;
        end else begin
          m_pfv = 1; m_pfa = m_tgt; m_pfd = fmem[m_tgt]; m_act = 0;
        end
      end
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0);
  endtask

  // Runs idle cycles until data_valid; lat = cycles from request t (bounded).
  task automatic wait_dv(input int t, output int lat, output int oel, output int bsy);
    lat = -1; oel = 0; bsy = 0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      cyc(0, 0, 16'h0);
      if (last_dv) lat = cyc_n - 1 - t;
      else begin
        if (!last_oe) oel++;
        if (last_busy) bsy++;
      end
    end
  endtask

  initial begin
    int t, t2, lat, oel, bsy;
    logic [15:0] la, ra;
    for (int i = 0; i < 65536; i++) fmem[i] = 16'($urandom);
    fmem[16'h0010] = 16'hA5C3;
    fmem[16'h0011] = 16'h1234;
    rst = 1; flash_ready = 0; flash_address = 0;
    m_reset();
    cyc(1, 0, 16'h0);
    chk_en = 1;
    cyc(1, 0, 16'h0);
    chk("rst_data", last_out, 16'h0000);
    chk("rst_ce", 16'(last_ce), 16'h1);
    chk("rst_maddr", last_maddr, 16'h0000);

    // demand fetch from cold
    cyc(0, 1, 16'h0010); t = cyc_n - 1;
    wait_dv(t, lat, oel, bsy);
    chk("t1_latency", 16'(lat), 16'(3 + WS));
    chk("t1_oe_low_cycles", 16'(oel), 16'(WS + 2));
    chk("t1_busy_cycles", 16'(bsy), 16'(WS + 2));
    chk("t1_data", last_out, 16'hA5C3);
    idle(10);
    chk("t1_held", last_out, 16'hA5C3);

    // prefetch hit on the sequential next word
    cyc(0, 1, 16'h0011);
    cyc(0, 0, 16'h0);
    chk("t2_hit_dv", 16'(last_dv), 16'h1);
    chk("t2_hit_data", last_out, 16'h1234);
    chk("t2_hit_busy", 16'(last_busy), 16'h0);
    chk("t2_pf_next_addr", last_maddr, 16'h0012);
    idle(10);

    // abort a prefetch with a different address
    cyc(0, 1, 16'h0010); t = cyc_n - 1;
    wait_dv(t, lat, oel, bsy);
    chk("t3_demand_lat", 16'(lat), 16'(3 + WS));
    cyc(0, 0, 16'h0);
    cyc(0, 1, 16'h0020); t2 = cyc_n - 1;
    cyc(0, 0, 16'h0);
    chk("t3_setup_addr", last_maddr, 16'h0020);
    chk("t3_setup_oe", 16'(last_oe), 16'h0);
    wait_dv(t2, lat, oel, bsy);
    chk("t3_latency", 16'(lat), 16'(3 + WS));
    chk("t3_data", last_out, fmem[16'h0020]);
    idle(12);

    // promote an in-flight prefetch (request 2 cycles after its SETUP)
    cyc(0, 1, 16'h0010); t = cyc_n - 1;
    idle(4 + WS);
    cyc(0, 1, 16'h0011); t2 = cyc_n - 1;
    wait_dv(t2, lat, oel, bsy);
    chk("t4_promote_lat", 16'(lat), 16'(WS));
    chk("t4_data", last_out, 16'h1234);
    chk("t4_overrun", 16'(last_ovr), 16'h0);
    idle(12);

    // request while busy is dropped
    cyc(0, 1, 16'h0030); t = cyc_n - 1;
    idle(2);
    cyc(0, 1, 16'h0040);
    wait_dv(t, lat, oel, bsy);
    chk("t5_latency", 16'(lat), 16'(3 + WS));
    chk("t5_data", last_out, fmem[16'h0030]);
    chk("t5_overrun", 16'(last_ovr), 16'h1);
    idle(12);
    chk("t5_overrun_sticky", 16'(last_ovr), 16'h1);

    // wrap prefetch, reset mid-access
    cyc(0, 1, 16'hFFFF); t = cyc_n - 1;
    wait_dv(t, lat, oel, bsy);
    chk("t6_data", last_out, fmem[16'hFFFF]);
    chk("t6_wrap_addr", last_maddr, 16'h0000);
    cyc(0, 0, 16'h0);
    cyc(1, 0, 16'h0);
    cyc(0, 0, 16'h0);
    chk("t6_rst_data", last_out, 16'h0000);
    chk("t6_rst_ce", 16'(last_ce), 16'h1);
    chk("t6_rst_oe", 16'(last_oe), 16'h1);
    chk("t6_rst_ovr", 16'(last_ovr), 16'h0);
    cyc(0, 1, 16'h0000); t = cyc_n - 1;
    wait_dv(t, lat, oel, bsy);
    chk("t6_miss_lat", 16'(lat), 16'(3 + WS));
    chk("t6_miss_data", last_out, fmem[16'h0000]);

    // randomized traffic
    la = 16'h0100;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        cyc(1, 0, 16'h0);
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: ra = la + 16'd1;
          1: ra = m_tgt;
          2: ra = 16'($urandom_range(16'h0100, 16'h0110));
          default: ra = 16'hFFFF - 16'($urandom_range(0, 1));
        endcase
        la = ra;
        cyc(0, 1, ra);
      end else begin
        cyc(0, 0, 16'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
